vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the video card's single-port synchronous VRAM between the display fetch path and the Z80 CPU bus interface.
- Runs on the 50 MHz master clock.
- Internally generates the 2-phase pixel slot (25 MHz pixel clock). Phase 0 is the display slot; phase 1 is always the CPU slot. During blanking, the CPU may also take phase 0.
- Gives the CPU a bounded access latency without ever stalling pixel output.

Parameters:
- ADDR_W, 13, VRAM address width
- DATA_W, 8, VRAM data width

Ports:
- clk  in  1  master clock, 50 MHz
- clr_n  in  1  asynchronous active-low reset
- pclk  out  1  pixel clock, 25 MHz (equals the slot phase bit)
- disp_en  in  1  display needs a fetch in the current pixel period (active video)
- disp_addr  in  ADDR_W  display fetch address
- disp_data  out  DATA_W  fetched display byte
- disp_valid  out  1  one-cycle strobe: disp_data updated
- cpu_req  in  1  single-cycle request strobe
- cpu_we  in  1  1 = write, 0 = read (sampled with cpu_req)
- cpu_addr  in  ADDR_W  CPU address (sampled with cpu_req)
- cpu_wdata  in  DATA_W  CPU write data (sampled with cpu_req)
- cpu_busy  out  1  request held; new strobes ignored
- cpu_ack  out  1  one-cycle completion strobe
- cpu_rdata  out  DATA_W  read result, valid when cpu_ack=1 after a read
- vram_addr  out  ADDR_W  RAM address
- vram_wdata  out  DATA_W  RAM write data
- vram_we  out  1  RAM write enable
- vram_rdata  in  DATA_W  RAM read data, one cycle after the address

Behaviour:
- Reset (clr_n=0, asynchronous):
  - phase=0, state=IDLE.
  - pclk, disp_valid, cpu_busy, cpu_ack, vram_we = 0.
  - disp_data, cpu_rdata, vram_addr, vram_wdata = 0.
  - Any held request is dropped and no ack is issued.
- Phase: toggles every clk after reset release. pclk=phase. The first rising edge of pclk occurs one clk after release.
- Slot owner, combinational from phase/disp_en/state:
  - phase=0 and disp_en=1: DISPLAY. vram_addr=disp_addr, vram_we=0.
  - phase=1, or phase=0 with disp_en=0: CPU, but only if state=PEND. Otherwise the slot is idle: vram_we=0 and vram_addr holds its last value.
- CPU FSM:
  - IDLE:
    - On cpu_req=1: latch we/addr/wdata, go to PEND, set cpu_busy=1 from the next cycle.
    - A request arriving in the same cycle as a CPU-eligible slot is NOT served that cycle. Service begins the following cycle.
  - PEND:
    - On an eligible CPU slot, drive the latched addr/wdata and vram_we=latched we.
    - Write: go to IDLE. cpu_ack=1 and cpu_busy=0 on the next cycle.
    - Read: go to RDW.
  - RDW: capture vram_rdata into cpu_rdata, pulse cpu_ack, clear cpu_busy, go to IDLE.
  - cpu_req while cpu_busy=1 is ignored. Any strobe in the ack cycle is also ignored.
- Display path:
  - A display issue at cycle T is captured at T+1.
  - disp_data is registered and disp_valid pulses at T+2 relative to the issue edge. disp_data holds between strobes.
- Latency, measured from the accept edge:
  - Write ack: 2–3 cycles.
  - Read ack: 3–4 cycles.
  - These are the worst case during active video. The CPU is never starved.
- RAM read turnaround: a display read at phase 0 followed by a CPU write at phase 1 is legal. vram_rdata for the display read is still captured.
- Reset mid-read (RDW): no ack. After release, cpu_busy=0 and state=IDLE.

Decomposition:
- Shared package `video_pkg`:
  - ADDR_W/DATA_W defaults.
  - State encoding: IDLE=2'd0, PEND=2'd1, RDW=2'd2.
  - Slot owner encoding: NONE, DISP, CPU.
- One natural sub-module: `slot_phase_gen`, the 2-phase divider with active-low async reset, emitting phase and pclk. It replaces the standalone divider in the top level.

Test Plan:
- Reset release, disp_en=0, no requests: pclk toggles every clk (25 MHz). vram_we=0, cpu_busy=0, disp_valid=0 throughout.
- disp_en=1, disp_addr=0x0100, RAM preloaded 0x0100=0xA5: disp_valid pulses 2 cycles after each phase-0 edge with disp_data=0xA5. vram_we is never asserted in phase 0.
- Active video (disp_en=1) plus CPU write strobe addr=0x1FFF data=0x3C at phase 0: write is issued at the next phase-1 slot. cpu_ack arrives within 3 cycles of the strobe. A later display read of 0x1FFF returns 0x3C.
- Blanking (disp_en=0), CPU read of addr 0x0042 holding 0x77: served in the next cycle regardless of phase. cpu_ack and cpu_rdata=0x77 arrive 3 cycles after the strobe.
- Second cpu_req while cpu_busy=1 (addr 0x0010): ignored. Only the first request's write lands. Exactly one cpu_ack is produced.
- clr_n pulsed low while in RDW: outputs go to reset values immediately and no cpu_ack is produced. After release, a new request completes normally.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types for the video card VRAM path: width defaults, CPU FSM state
// encoding and slot-owner decode.
package video_pkg;

  localparam int ADDR_W_DFLT = 13;
  localparam int DATA_W_DFLT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RDW  = 2'd2
  } cpu_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } slot_owner_t;

  // Display owns phase 0 during active video; every other slot is the CPU's,
  // but only when a request is actually pending.
  function automatic slot_owner_t slot_owner(input logic phase,
                                             input logic disp_en,
                                             input cpu_state_t st);
    slot_owner_t own;
    if (!phase && disp_en)
      own = OWN_DISP;
    else if (st == PEND)
      own = OWN_CPU;
    else
      own = OWN_NONE;
    return own;
  endfunction

endpackage

// File: rtl/slot_phase_gen.sv
// Two-phase slot divider: phase toggles every clk, pclk mirrors it (clk/2).
// Zero latency; no backpressure.
module slot_phase_gen (
  input  logic clk,
  input  logic clr_n,
  output logic phase,
  output logic pclk
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      phase <= 1'b0;
    else
      phase <= ~phase;
  end

  assign pclk = phase;

endmodule

// File: rtl/vram_arbiter.sv
// Shares single-port VRAM between display fetch (phase 0) and CPU (phase 1, or any idle slot).
// Display data 2 clk after issue; CPU ack 2-3 clk (write) / 3-4 clk (read); strobes ignored while busy.
module vram_arbiter
  import video_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              clr_n,
  output logic              pclk,
  input  logic              disp_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              vram_we,
  input  logic [DATA_W-1:0] vram_rdata
);

  logic              phase;
  cpu_state_t        state_q, state_d;
  slot_owner_t       owner;
  logic              accept;
  logic              ack_d;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [ADDR_W-1:0] hold_addr;
  logic              disp_issue_q;

  slot_phase_gen u_phase (
    .clk   (clk),
    .clr_n (clr_n),
    .phase (phase),
    .pclk  (pclk)
  );

  assign owner = slot_owner(phase, disp_en, state_q);

  // The ack cycle is already IDLE, so a strobe there must be masked explicitly.
  assign accept   = (state_q == IDLE) && cpu_req && !cpu_ack;
  assign cpu_busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = PEND;
      end
      PEND: begin
        if (owner == OWN_CPU) begin
          if (lat_we) begin
            state_d = IDLE;
            ack_d   = 1'b1;
          end else begin
            state_d = RDW;
          end
        end
      end
      RDW: begin
        state_d = IDLE;
        ack_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle slots keep the previous address so the RAM pins stay quiet.
  always_comb begin
    vram_addr = hold_addr;
    vram_we   = 1'b0;
    case (owner)
      OWN_DISP: vram_addr = disp_addr;
      OWN_CPU: begin
        vram_addr = lat_addr;
        vram_we   = lat_we;
      end
      default: ;
    endcase
  end

  assign vram_wdata = lat_wdata;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= IDLE;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      hold_addr    <= '0;
      disp_issue_q <= 1'b0;
      disp_valid   <= 1'b0;
      disp_data    <= '0;
    end else begin
      state_q      <= state_d;
      cpu_ack      <= ack_d;
      hold_addr    <= vram_addr;
      disp_issue_q <= (owner == OWN_DISP);
      disp_valid   <= disp_issue_q;
      if (accept) begin
        lat_we    <= cpu_we;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
      end
      if (state_q == RDW)
        cpu_rdata <= vram_rdata;
      if (disp_issue_q)
        disp_data <= vram_rdata;
    end
  end

endmodule
